loop_ctrl_arb: RTL and testbench

//  Scheduler for the shared bounded-loop counter (i runs from 0 up to a limit y, under a ceiling x).

---
 rtl/loop_ctrl_pkg.sv | 11 +
 rtl/loop_ctrl_arb_rr_arb2.sv | 19 +
 rtl/loop_ctrl_arb.sv | 101 ++++++++++
 tb/tb_loop_ctrl_arb.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/loop_ctrl_pkg.sv
// loop_ctrl_pkg: shared types and defaults for the bounded-loop scheduler.
// Holds the FSM state encoding and default datapath width / reset values.
package loop_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam int W_DEF     = 15;
    localparam int RST_X_DEF = 500;
    localparam int RST_Y_DEF = 399;

endpackage

// File: rtl/loop_ctrl_arb_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
// Ports:
//   req  in  2  request levels
//   ptr  in  1  favoured requester when both request
//   gnt  out 2  one-hot grant, 0 when nobody requests
//   idx  out 1  index of the granted requester
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt,
    output logic       idx
);

    always_comb begin
        idx = (&req) ? ptr : req[1];
        gnt = (|req) ? (idx ? 2'b10 : 2'b01) : 2'b00;
    end

endmodule

// File: rtl/loop_ctrl_arb.sv
// loop_ctrl_arb: scheduler for the shared bounded-loop counter.
// Arbitrates two requesters round-robin, loads the granted limit into y,
// steps i from 0 to y on selector, pulses done at completion and flags
// breaks of the invariant !(i<y && i>=x) in a sticky violation bit.
// Ports:
//   clk, rst            clock, async active-high reset
//   selector            counter step enable in RUN
//   req[1:0]            level requests, held until their done
//   lim0, lim1          per-requester loop limits, sampled at grant
//   cfg_we, cfg_x       ceiling write, honoured only in IDLE
//   abort               cancel the active loop
//   viol_clr            clear the violation flag
//   grant, busy         one-hot owner (LOAD..DONE), state != IDLE
//   done, done_id       completion pulse and owner index
//   i, y, x             counter, active limit, ceiling
//   violation           sticky invariant-break flag
module loop_ctrl_arb
    import loop_ctrl_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int RST_X = RST_X_DEF,
    parameter int RST_Y = RST_Y_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         selector,
    input  logic [1:0]   req,
    input  logic [W-1:0] lim0,
    input  logic [W-1:0] lim1,
    input  logic         cfg_we,
    input  logic [W-1:0] cfg_x,
    input  logic         abort,
    input  logic         viol_clr,
    output logic [1:0]   grant,
    output logic         busy,
    output logic         done,
    output logic         done_id,
    output logic [W-1:0] i,
    output logic [W-1:0] y,
    output logic [W-1:0] x,
    output logic         violation
);

    state_t     state, nxt;
    logic       win, rr_ptr, arb_idx, viol_set;
    logic [1:0] arb_gnt;

    rr_arb2 u_arb (
        .req (req),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE: nxt = (|arb_gnt) ? LOAD : IDLE;
            LOAD: nxt = abort ? IDLE : RUN;
            RUN:  nxt = abort ? IDLE : (i >= y ? DONE : RUN);
            DONE: nxt = IDLE;
        endcase
    end

    // Owner is latched once at grant, so grant/done_id follow it directly.
    always_comb begin
        busy     = state != IDLE;
        grant    = busy ? (win ? 2'b10 : 2'b01) : 2'b00;
        done     = state == DONE;
        done_id  = win;
        viol_set = state == RUN && i < y && i >= x;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            win       <= 1'b0;
            rr_ptr    <= 1'b0;
            i         <= '0;
            y         <= W'(RST_Y);
            x         <= W'(RST_X);
            violation <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && |arb_gnt) begin
                win <= arb_idx;
                y   <= arb_idx ? lim1 : lim0;
                i   <= '0;
            end
            if (state == IDLE && cfg_we)
                x <= cfg_x;
            // i < y guarantees the increment never wraps, even for y = 2^W-1.
            if (state == RUN && !abort && i < y && selector)
                i <= i + 1'b1;
            if ((state == RUN && abort) || state == DONE)
                rr_ptr <= ~win;
            violation <= viol_set | (violation & ~viol_clr);
        end
    end

endmodule

// File: tb/tb_loop_ctrl_arb.sv
// tb_loop_ctrl_arb: randomized self-checking bench for loop_ctrl_arb.
// A transaction-level model tracks the round-robin favourite, the ceiling,
// the expected counter value and the sticky violation flag.
module tb_loop_ctrl_arb;
    import loop_ctrl_pkg::*;

    localparam int W = W_DEF;

    logic         clk = 1'b0, rst = 1'b1, selector = 1'b0, cfg_we = 1'b0, abort = 1'b0, viol_clr = 1'b0;
    logic [1:0]   req = 2'b00;
    logic [W-1:0] lim0 = '0, lim1 = '0, cfg_x = '0;
    logic [1:0]   grant;
    logic         busy, done, done_id, violation;
    logic [W-1:0] i, y, x;

    int n_cmp = 0, n_bad = 0;
    logic [W-1:0] m_x;
    logic         m_ptr, m_viol;

    always #5 clk = ~clk;

    loop_ctrl_arb dut (
        .clk(clk), .rst(rst), .selector(selector), .req(req), .lim0(lim0), .lim1(lim1),
        .cfg_we(cfg_we), .cfg_x(cfg_x), .abort(abort), .viol_clr(viol_clr),
        .grant(grant), .busy(busy), .done(done), .done_id(done_id),
        .i(i), .y(y), .x(x), .violation(violation)
    );

    task automatic quiet();
        selector = 0; cfg_we = 0; abort = 0; viol_clr = 0; req = 0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        m_x = W'(500); m_ptr = 0; m_viol = 0;
    endtask

    // One full transaction from an IDLE cycle. abort_i / rst_i (>=0) cancel
    // the loop once the counter shows that value in RUN.
    task automatic run_loop(input logic [1:0] r, input logic [W-1:0] l0, input logic [W-1:0] l1,
                            input int pct, input int abort_i, input int rst_i,
                            input logic we0, input logic [W-1:0] x0, input logic noise);
        logic win, set, fin, stop;
        logic [1:0] oh;
        logic [W-1:0] ey, ei;
        int c;
        req = r; lim0 = l0; lim1 = l1; cfg_we = we0; cfg_x = x0;
        win = (r == 2'b11) ? m_ptr : r[1];
        oh = win ? 2'b10 : 2'b01;
        ey = win ? l1 : l0;
        ei = '0;
        if (we0) m_x = x0;
        @(negedge clk);
        cfg_we = 0;
        n_cmp++;
        if ({grant, busy, done, i, y, x} !== {oh, 1'b1, 1'b0, W'(0), ey, m_x}) begin
            n_bad++;
            $display("FAIL grant_load: got grant=%b busy=%b done=%b i=%0d y=%0d x=%0d want grant=%b busy=1 done=0 i=0 y=%0d x=%0d",
                     grant, busy, done, i, y, x, oh, ey, m_x);
        end
        c = 1; fin = 0; stop = 0;
        while (!stop) begin
            selector = ($urandom_range(99) < pct);
            abort    = (c >= 2 && abort_i >= 0 && int'(ei) == abort_i);
            cfg_we   = noise && ($urandom_range(3) == 0);
            cfg_x    = W'($urandom);
            viol_clr = noise && ($urandom_range(7) == 0);
            if (c >= 2 && rst_i >= 0 && int'(ei) == rst_i) begin
                #2 rst = 1;
                #1;
                n_cmp++;
                if ({i, y, x, grant, busy, done, violation} !== {W'(0), W'(399), W'(500), 2'b00, 1'b0, 1'b0, 1'b0}) begin
                    n_bad++;
                    $display("FAIL async_reset: got i=%0d y=%0d x=%0d grant=%b busy=%b done=%b viol=%b want i=0 y=399 x=500 grant=00 busy=0 done=0 viol=0",
                             i, y, x, grant, busy, done, violation);
                end
                @(negedge clk);
                rst = 0;
                m_x = W'(500); m_ptr = 0; m_viol = 0;
                quiet();
                return;
            end
            set = (c >= 2) && ei < ey && ei >= m_x;
            m_viol = set | (m_viol & ~viol_clr);
            if (c >= 2 && abort) begin m_ptr = ~win; stop = 1; end
            else if (c >= 2 && ei >= ey) fin = 1;
            else if (c >= 2 && selector) ei++;
            @(negedge clk);
            c++;
            n_cmp++;
            if (stop) begin
                if ({busy, grant, done, violation, x} !== {1'b0, 2'b00, 1'b0, m_viol, m_x}) begin
                    n_bad++;
                    $display("FAIL abort_idle: got busy=%b grant=%b done=%b viol=%b x=%0d want busy=0 grant=00 done=0 viol=%b x=%0d",
                             busy, grant, done, violation, x, m_viol, m_x);
                end
            end else if ({done, busy, grant, i, violation, x} !== {fin, 1'b1, oh, ei, m_viol, m_x}) begin
                n_bad++;
                $display("FAIL loop_cycle%0d: got done=%b busy=%b grant=%b i=%0d viol=%b x=%0d want done=%b busy=1 grant=%b i=%0d viol=%b x=%0d",
                         c, done, busy, grant, i, violation, x, fin, oh, ei, m_viol, m_x);
            end
            if (fin) begin
                n_cmp++;
                if (done_id !== win) begin
                    n_bad++;
                    $display("FAIL done_id: got %b want %b", done_id, win);
                end
                quiet();
                m_ptr = ~win;
                @(negedge clk);
                n_cmp++;
                if ({busy, grant, done, violation} !== {1'b0, 2'b00, 1'b0, m_viol}) begin
                    n_bad++;
                    $display("FAIL after_done: got busy=%b grant=%b done=%b viol=%b want busy=0 grant=00 done=0 viol=%b",
                             busy, grant, done, violation, m_viol);
                end
                stop = 1;
            end
            if (c > 70000) begin
                n_cmp++; n_bad++;
                $display("FAIL loop_timeout: got no done after %0d cycles want done", c);
                stop = 1;
            end
        end
        quiet();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({i, y, x, grant, busy, done, done_id, violation} !== {W'(0), W'(399), W'(500), 2'b00, 4'b0000}) begin
            n_bad++;
            $display("FAIL reset: got i=%0d y=%0d x=%0d grant=%b busy=%b done=%b id=%b viol=%b want 0/399/500/00/0/0/0/0",
                     i, y, x, grant, busy, done, done_id, violation);
        end
    endtask

    task automatic test_single();
        run_loop(2'b01, W'(3), W'(0), 100, -1, -1, 0, '0, 0);
    endtask

    task automatic test_arbitration();
        do_reset();
        run_loop(2'b11, W'($urandom_range(8)), W'($urandom_range(8)), 100, -1, -1, 0, '0, 0);
        run_loop(2'b11, W'($urandom_range(8)), W'($urandom_range(8)), 100, -1, -1, 0, '0, 0);
        run_loop(2'b11, W'($urandom_range(12)), W'($urandom_range(12)), 50, -1, -1, 0, '0, 0);
    endtask

    task automatic test_boundary();
        run_loop(2'b10, W'(5), W'(0), 100, -1, -1, 0, '0, 0);
        run_loop(2'b01, W'(32767), W'(0), 100, -1, -1, 0, '0, 0);
    endtask

    task automatic test_violation();
        run_loop(2'b01, W'(5), W'(0), 100, -1, -1, 1, W'(2), 1);
        viol_clr = 1;
        @(negedge clk);
        viol_clr = 0;
        m_viol = 0;
        n_cmp++;
        if (violation !== 1'b0) begin
            n_bad++;
            $display("FAIL viol_clr: got %b want 0", violation);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 8; n++) begin
            logic [1:0] r;
            r = 2'($urandom_range(1, 3));
            run_loop(r, W'($urandom_range(15)), W'($urandom_range(15)), 70, -1, -1,
                     1'($urandom_range(1)), W'($urandom_range(10)), 1);
        end
    endtask

    task automatic test_abort();
        run_loop(2'b01, W'(9), W'(0), 100, 4, -1, 0, '0, 0);
        run_loop(2'b11, W'(2), W'(3), 100, -1, -1, 0, '0, 0);
    endtask

    task automatic test_async_reset();
        run_loop(2'b01, W'(10), W'(0), 100, -1, 7, 0, '0, 0);
        run_loop(2'b11, W'(1), W'(4), 100, -1, -1, 0, '0, 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_arbitration();
        test_boundary();
        test_violation();
        test_back_to_back();
        test_abort();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
